dac_play_sequencer: RTL and testbench

DAC_PLAY_SEQUENCER -- requirements
Module: dac_play_sequencer

---
 rtl/dac_play_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dac_play_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_play_sequencer.sv
// Multi-channel DAC playback sequencer: fires per-channel triggers at programmed offsets inside a repeating period.
// Optional build macro SEQ_EXT_TRIG_EN: every period waits for a synchronized rising edge on ext_trig.
module dac_play_sequencer #(
  parameter  int N_CH  = 8,
  parameter  int OFS_W = 16,
  localparam int AW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [OFS_W-1:0] cfg_data,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [31:0]      period,
  input  logic [15:0]      repeat_count,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  ch_ready,
`ifdef SEQ_EXT_TRIG_EN
  input  logic             ext_trig,
`endif
  output logic [N_CH-1:0]  trigger_out,
  output logic [N_CH-1:0]  select_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      rep_cnt
);

  localparam int CMPW = (OFS_W > 32) ? OFS_W : 32;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       perM1_q, perM1_d;
  logic [15:0]       repCnt_q, repCnt_d;
  logic [15:0]       rptNum_q, rptNum_d;
  logic [15:0]       repInc;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   trig_q, trig_d;
  logic [N_CH-1:0]   sel_q, sel_d;
  logic              busy_q, done_q, done_d;
  logic              wrap, finalRep;
  logic              waitTrig_q;
  logic [OFS_W-1:0]  offset_q [N_CH];
  logic [OFS_W-1:0]  offAct_q [N_CH];

`ifdef SEQ_EXT_TRIG_EN
  logic [2:0] extSync_q;
  logic       trigEdge;
  logic       waitTrig_d;

  assign trigEdge = extSync_q[1] & ~extSync_q[2];

  // Each period parks in WAIT_TRIG with cnt held at 0; edges seen while counting are dropped.
  always_comb begin
    waitTrig_d = waitTrig_q;
    if (state_q == ARM) begin
      waitTrig_d = 1'b1;
    end else if (state_q == RUN) begin
      if (waitTrig_q && trigEdge) waitTrig_d = 1'b0;
      else if (wrap)              waitTrig_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      extSync_q  <= '0;
      waitTrig_q <= 1'b0;
    end else begin
      extSync_q  <= {extSync_q[1:0], ext_trig};
      waitTrig_q <= waitTrig_d;
    end
  end
`else
  assign waitTrig_q = 1'b0;
`endif

  assign repInc = repCnt_q + 16'd1;
  assign wrap   = (state_q == RUN) && !waitTrig_q && (cnt_q == perM1_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    repCnt_d = repCnt_q;
    mask_d   = mask_q;
    perM1_d  = perM1_q;
    rptNum_d = rptNum_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d   = ch_mask;
          perM1_d  = (period == 32'd0) ? 32'd0 : period - 32'd1;
          rptNum_d = repeat_count;
          if (ch_mask != '0) begin
            state_d  = ARM;
            repCnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else if ((ch_ready & mask_q) == mask_q) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wrap) begin
          cnt_d    = '0;
          repCnt_d = repInc;
          if (rptNum_q != '0 && repInc == rptNum_q) state_d = DONE;
        end else if (!waitTrig_q) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) done_d = 1'b1;
    // Loopback is dropped for the last repetition so the FIFOs drain instead of recirculating.
    finalRep = (rptNum_d != '0) && (repCnt_d == rptNum_d - 16'd1);
    sel_d    = '0;
    if (state_d == ARM || (state_d == RUN && !finalRep)) sel_d = mask_d;
  end

  always_comb begin
    trig_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      trig_d[i] = (state_q == RUN) && !waitTrig_q && !abort && mask_q[i] &&
                  (CMPW'(offAct_q[i]) == CMPW'(cnt_q));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      perM1_q  <= '0;
      repCnt_q <= '0;
      rptNum_q <= '0;
      mask_q   <= '0;
      trig_q   <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      perM1_q  <= perM1_d;
      repCnt_q <= repCnt_d;
      rptNum_q <= rptNum_d;
      mask_q   <= mask_d;
      trig_q   <= trig_d;
      sel_q    <= sel_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
    end
  end

  // Offsets written mid-run only reach the active copy at a period boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        offset_q[i] <= '0;
        offAct_q[i] <= '0;
      end
    end else begin
      if (cfg_wr) offset_q[cfg_addr] <= cfg_data;
      if (state_q != RUN || wrap) begin
        for (int i = 0; i < N_CH; i++) offAct_q[i] <= offset_q[i];
      end
    end
  end

  assign trigger_out = trig_q;
  assign select_out  = sel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rep_cnt     = repCnt_q;

endmodule

// File: tb/tb_dac_play_sequencer.sv
// Directed bench for dac_play_sequencer: table of full play scenarios plus hand-written corner sequences.
// Inputs change and outputs are sampled on the falling clock edge; sample s is the one after rising edge s.
module tb_dac_play_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [7:0]  ch_mask;
  logic [31:0] period;
  logic [15:0] repeat_count;
  logic        start;
  logic        abort;
  logic [7:0]  ch_ready;
  logic [7:0]  trigger_out;
  logic [7:0]  select_out;
  logic        busy;
  logic        done;
  logic [15:0] rep_cnt;
`ifdef SEQ_EXT_TRIG_EN
  logic        extTrig;
`endif

  int assertCount = 0;
  int failCount   = 0;

  dac_play_sequencer #(.N_CH(8), .OFS_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .ch_mask      (ch_mask),
    .period       (period),
    .repeat_count (repeat_count),
    .start        (start),
    .abort        (abort),
    .ch_ready     (ch_ready),
`ifdef SEQ_EXT_TRIG_EN
    .ext_trig     (extTrig),
`endif
    .trigger_out  (trigger_out),
    .select_out   (select_out),
    .busy         (busy),
    .done         (done),
    .rep_cnt      (rep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [7:0]       mask;
    logic [31:0]      period;
    logic [15:0]      rpt;
    logic [2:0][15:0] off;
    logic [2:0][7:0]  expCnt;
    logic [2:0][7:0]  expFirst;
    logic [2:0][7:0]  expLast;
    logic [7:0]       expDone;
    logic [15:0]      expRep;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mkVec(input logic [7:0] m, input logic [31:0] p, input logic [15:0] r,
                                 input logic [15:0] o0, o1, o2,
                                 input logic [7:0] c0, c1, c2, f0, f1, f2, l0, l1, l2,
                                 input logic [7:0] dn, input logic [15:0] rp);
    vec_t v;
    v.mask = m;  v.period = p;  v.rpt = r;
    v.off[0] = o0;  v.off[1] = o1;  v.off[2] = o2;
    v.expCnt[0] = c0;  v.expCnt[1] = c1;  v.expCnt[2] = c2;
    v.expFirst[0] = f0;  v.expFirst[1] = f1;  v.expFirst[2] = f2;
    v.expLast[0] = l0;  v.expLast[1] = l1;  v.expLast[2] = l2;
    v.expDone = dn;  v.expRep = rp;
    return v;
  endfunction

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [31:0] p, input logic [15:0] r);
    ch_mask      = m;
    period       = p;
    repeat_count = r;
  endtask

  task automatic writeOffset(input int ch, input logic [15:0] val);
    cfg_wr   = 1'b1;
    cfg_addr = 3'(ch);
    cfg_data = val;
    nextCycle();
    cfg_wr   = 1'b0;
  endtask

  // Plays one table row from IDLE and records every trigger position and the done sample.
  task automatic runScenario(input int r);
    vec_t v;
    int   cnt [3];
    int   first [3];
    int   last [3];
    int   doneAt;
    logic [7:0] extra;
    v = vecs[r];
    for (int c = 0; c < 3; c++) writeOffset(c, v.off[c]);
    applyStimulus(v.mask, v.period, v.rpt);
    ch_ready = 8'hFF;
    for (int c = 0; c < 3; c++) begin cnt[c] = 0; first[c] = 0; last[c] = 0; end
    doneAt = 0;
    extra  = '0;
    start  = 1'b1;
    for (int s = 1; s <= 200 && doneAt == 0; s++) begin
      nextCycle();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (trigger_out[c]) begin
          cnt[c]++;
          if (first[c] == 0) first[c] = s;
          last[c] = s;
        end
      end
      extra |= trigger_out & 8'hF8;
      if (done) doneAt = s;
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("row%0d ch%0d trigger count", r, c), cnt[c], v.expCnt[c]);
      checkOutput($sformatf("row%0d ch%0d first trigger", r, c), first[c], v.expFirst[c]);
      checkOutput($sformatf("row%0d ch%0d last trigger", r, c), last[c], v.expLast[c]);
    end
    checkOutput($sformatf("row%0d unmasked triggers", r), extra, 0);
    checkOutput($sformatf("row%0d done sample", r), doneAt, v.expDone);
    checkOutput($sformatf("row%0d rep_cnt", r), rep_cnt, v.expRep);
    nextCycle();
    checkOutput($sformatf("row%0d done single pulse", r), done, 0);
    checkOutput($sformatf("row%0d busy after done", r), busy, 0);
  endtask

  initial begin
    rst = 1'b0;  cfg_wr = 1'b0;  cfg_addr = '0;  cfg_data = '0;
    ch_mask = '0;  period = '0;  repeat_count = '0;
    start = 1'b0;  abort = 1'b0;  ch_ready = 8'hFF;
`ifdef SEQ_EXT_TRIG_EN
    extTrig = 1'b0;
`endif

    vecs[0] = mkVec(8'h03, 10, 3, 0, 5, 0,  3, 3, 0,  3, 8, 0,  23, 28, 0,  32, 3);
    vecs[1] = mkVec(8'h07, 10, 2, 0, 5, 12, 2, 2, 0,  3, 8, 0,  13, 18, 0,  22, 2);
    vecs[2] = mkVec(8'h01, 0,  5, 0, 0, 0,  5, 0, 0,  3, 0, 0,  7, 0, 0,    7,  5);
    vecs[3] = mkVec(8'h04, 4,  2, 0, 0, 3,  0, 0, 2,  0, 0, 6,  0, 0, 10,   10, 2);
    vecs[4] = mkVec(8'h03, 3,  1, 2, 1, 0,  1, 1, 0,  5, 4, 0,  5, 4, 0,    5,  1);

    repeat (2) nextCycle();
    checkOutput("reset trigger_out", trigger_out, 0);
    checkOutput("reset select_out", select_out, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset rep_cnt", rep_cnt, 0);
    rst = 1'b1;
    nextCycle();
    checkOutput("idle busy after release", busy, 0);

`ifdef SEQ_EXT_TRIG_EN
    begin
      int tcnt, tfirst, tlast, doneAt;
      writeOffset(0, 16'd0);
      applyStimulus(8'h01, 10, 2);
      tcnt = 0; tfirst = 0; tlast = 0; doneAt = 0;
      start = 1'b1;
      for (int s = 1; s <= 160 && doneAt == 0; s++) begin
        nextCycle();
        if (s == 1) start = 1'b0;
        if (trigger_out[0]) begin
          tcnt++;
          if (tfirst == 0) tfirst = s;
          tlast = s;
        end
        if (done) doneAt = s;
        case (s)
          19:  checkOutput("ext waiting busy", busy, 1);
          20:  extTrig = 1'b1;
          24:  extTrig = 1'b0;
          26:  extTrig = 1'b1;
          30:  extTrig = 1'b0;
          60:  checkOutput("ext one period per edge rep_cnt", rep_cnt, 1);
          120: extTrig = 1'b1;
          125: extTrig = 1'b0;
          default: ;
        endcase
      end
      checkOutput("ext trigger count", tcnt, 2);
      checkOutput("ext first trigger", tfirst, 24);
      checkOutput("ext last trigger", tlast, 124);
      checkOutput("ext done sample", doneAt, 133);
      checkOutput("ext rep_cnt", rep_cnt, 2);
    end
`else
    for (int r = 0; r < 5; r++) runScenario(r);

    // Channel 1 not loaded: sequencer must hold in ARM until it is.
    begin
      int doneAt;
      writeOffset(0, 16'd0);
      writeOffset(1, 16'd0);
      applyStimulus(8'h03, 10, 1);
      ch_ready = 8'h01;
      doneAt   = 0;
      start    = 1'b1;
      for (int s = 1; s <= 30; s++) begin
        nextCycle();
        if (s == 1) start = 1'b0;
        if (done && doneAt == 0) doneAt = s;
        case (s)
          2, 5: begin
            checkOutput($sformatf("arm wait busy s%0d", s), busy, 1);
            checkOutput($sformatf("arm wait trigger s%0d", s), trigger_out, 0);
            checkOutput($sformatf("arm wait select s%0d", s), select_out, 8'h03);
          end
          6: begin
            checkOutput("arm exit first run cycle trigger", trigger_out, 0);
            checkOutput("single rep select in run", select_out, 0);
          end
          7: checkOutput("arm exit offset0 triggers", trigger_out, 8'h03);
          default: ;
        endcase
        if (s == 5) ch_ready = 8'h03;
      end
      checkOutput("arm wait done sample", doneAt, 16);
      ch_ready = 8'hFF;
    end

    // Loopback select across a two-repetition run.
    begin
      applyStimulus(8'h03, 10, 2);
      start = 1'b1;
      for (int s = 1; s <= 23; s++) begin
        nextCycle();
        if (s == 1) start = 1'b0;
        case (s)
          1, 2, 11: checkOutput($sformatf("select rep1 s%0d", s), select_out, 8'h03);
          12: begin
            checkOutput("select rep2 start", select_out, 8'h00);
            checkOutput("rep_cnt after first rep", rep_cnt, 1);
          end
          21: checkOutput("select rep2 end", select_out, 8'h00);
          22: checkOutput("select two-rep done", done, 1);
          23: checkOutput("two-rep idle", busy, 0);
          default: ;
        endcase
      end
    end

    // Infinite run: ignored restart, then abort at run cycle 50.
    begin
      int doneSeen;
      writeOffset(0, 16'd0);
      writeOffset(1, 16'd5);
      applyStimulus(8'h03, 10, 0);
      doneSeen = 0;
      start    = 1'b1;
      for (int s = 1; s <= 53; s++) begin
        nextCycle();
        start = 1'b0;
        if (done) doneSeen++;
        case (s)
          30: begin
            applyStimulus(8'h0F, 3, 1);
            start = 1'b1;
          end
          31: checkOutput("restart while busy select", select_out, 8'h03);
          40: checkOutput("infinite select", select_out, 8'h03);
          43: checkOutput("infinite ch0 trigger", trigger_out, 8'h01);
          48: checkOutput("infinite ch1 trigger", trigger_out, 8'h02);
          52: abort = 1'b1;
          53: begin
            abort = 1'b0;
            checkOutput("abort busy", busy, 0);
            checkOutput("abort trigger_out", trigger_out, 0);
            checkOutput("abort select_out", select_out, 0);
            checkOutput("abort rep_cnt held", rep_cnt, 5);
          end
          default: ;
        endcase
      end
      repeat (3) begin
        nextCycle();
        if (done) doneSeen++;
      end
      checkOutput("abort no done pulse", doneSeen, 0);

      applyStimulus(8'h03, 10, 1);
      start = 1'b1;
      abort = 1'b1;
      nextCycle();
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start+abort busy", busy, 0);
      checkOutput("start+abort select", select_out, 0);
      checkOutput("start+abort done", done, 0);
      nextCycle();
      checkOutput("start+abort stays idle", busy, 0);
      checkOutput("idle holds rep_cnt", rep_cnt, 5);
    end

    // Start with an empty mask completes immediately.
    begin
      applyStimulus(8'h00, 10, 1);
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      checkOutput("empty mask done", done, 1);
      checkOutput("empty mask busy", busy, 0);
      nextCycle();
      checkOutput("empty mask done one cycle", done, 0);
      checkOutput("empty mask rep_cnt held", rep_cnt, 5);
    end

    // Offset rewritten mid-period applies from the next period.
    begin
      writeOffset(0, 16'd2);
      applyStimulus(8'h01, 10, 0);
      start = 1'b1;
      for (int s = 1; s <= 20; s++) begin
        nextCycle();
        start = 1'b0;
        case (s)
          5:  checkOutput("old offset fires", trigger_out, 8'h01);
          7: begin
            cfg_wr = 1'b1; cfg_addr = 3'd0; cfg_data = 16'd6;
          end
          8:  cfg_wr = 1'b0;
          9:  checkOutput("new offset not yet active", trigger_out, 8'h00);
          15: checkOutput("old offset retired", trigger_out, 8'h00);
          19: checkOutput("new offset fires", trigger_out, 8'h01);
          20: abort = 1'b1;
          default: ;
        endcase
      end
      nextCycle();
      abort = 1'b0;
      checkOutput("offset test aborted", busy, 0);
    end

    // Asynchronous reset in the middle of a run.
    begin
      writeOffset(0, 16'd0);
      applyStimulus(8'h01, 10, 0);
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (4) nextCycle();
      #2 rst = 1'b0;
      #1;
      checkOutput("async reset busy", busy, 0);
      checkOutput("async reset trigger", trigger_out, 0);
      checkOutput("async reset select", select_out, 0);
      checkOutput("async reset rep_cnt", rep_cnt, 0);
      nextCycle();
      rst = 1'b1;
      nextCycle();
      checkOutput("after reset no done", done, 0);
      checkOutput("after reset idle", busy, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
